// File: rtl/rv_pkg.sv
// Shared types and helpers for the rv_bpu branch predictor.
// Index/tag extraction and saturating-counter arithmetic.
package rv_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bpu_state_e;

    typedef struct packed {
        logic        valid;
        logic [63:0] tag;
        logic [63:0] target;
        logic        jump;
    } btb_entry_t;

    function automatic logic [31:0] cnt_init(input int w);
        return (w <= 1) ? 32'd0 : ((32'd1 << (w - 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] cnt_max(input int w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] cnt_step(
        input logic [31:0] v,
        input int          w,
        input logic        up
    );
        logic [31:0] mx;
        mx = cnt_max(w);
        if (up) return (v >= mx) ? v : v + 32'd1;
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

    function automatic logic [63:0] pc_field(
        input logic [63:0] pc,
        input int          lsb,
        input int          w
    );
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (pc >> lsb) & m;
    endfunction

endpackage

// File: rtl/rv_bpu_sat_cnt.sv
// One BHT entry: CNT_W-bit saturating counter.
// Clear has priority over inc, inc over dec.
module rv_bpu_sat_cnt
    import rv_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] INIT = CNT_W'(cnt_init(CNT_W));

    logic [CNT_W-1:0] r_cnt;

    // counter state: weakly-not-taken on reset or clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= INIT;
        end else if (i_clr) begin
            r_cnt <= INIT;
        end else if (i_inc) begin
            r_cnt <= CNT_W'(cnt_step(32'(r_cnt), CNT_W, 1'b1));
        end else if (i_dec) begin
            r_cnt <= CNT_W'(cnt_step(32'(r_cnt), CNT_W, 1'b0));
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/rv_bpu.sv
// Branch prediction unit: BHT of saturating counters, tagged BTB,
// EX-stage mispredict detection, table-clear FSM, perf counters.
module rv_bpu
    import rv_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16,
    parameter int CNT_W       = 2,
    parameter int TAG_W       = 12
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] if_pc_i,
    output logic            if_pred_taken_o,
    output logic [XLEN-1:0] if_pred_target_o,
    input  logic            ex_valid_i,
    input  logic            ex_is_jump_i,
    input  logic [XLEN-1:0] ex_pc_i,
    input  logic            ex_taken_i,
    input  logic [XLEN-1:0] ex_target_i,
    input  logic            ex_pred_taken_i,
    input  logic [XLEN-1:0] ex_pred_target_i,
    output logic            mispredict_o,
    output logic [XLEN-1:0] redirect_pc_o,
    input  logic            flush_i,
    output logic            busy_o,
    output logic [31:0]     perf_branches_o,
    output logic [31:0]     perf_mispredicts_o
);

    localparam int BHT_W = $clog2(BHT_ENTRIES);
    localparam int BTB_W = $clog2(BTB_ENTRIES);

    bpu_state_e       r_state;
    bpu_state_e       w_state_nxt;
    logic [BHT_W-1:0] r_clr_idx;
    logic [BHT_W-1:0] w_clr_idx_nxt;

    btb_entry_t       r_btb [BTB_ENTRIES];
    logic [CNT_W-1:0] w_cnt [BHT_ENTRIES];

    logic [31:0]      r_perf_br;
    logic [31:0]      r_perf_mp;

    logic [63:0]      w_if_pc;
    logic [63:0]      w_ex_pc;
    logic [BHT_W-1:0] w_lk_bidx;
    logic [BHT_W-1:0] w_ex_bidx;
    logic [BTB_W-1:0] w_lk_tidx;
    logic [BTB_W-1:0] w_ex_tidx;
    logic [63:0]      w_lk_tag;
    logic [63:0]      w_ex_tag;
    btb_entry_t       w_lk_ent;
    logic             w_hit;
    logic             w_idle;
    logic             w_clr;
    logic             w_act;
    logic             w_upd;
    logic             w_upd_cond;

    assign w_if_pc   = 64'(if_pc_i);
    assign w_ex_pc   = 64'(ex_pc_i);
    assign w_lk_bidx = BHT_W'(pc_field(w_if_pc, 2, BHT_W));
    assign w_ex_bidx = BHT_W'(pc_field(w_ex_pc, 2, BHT_W));
    assign w_lk_tidx = BTB_W'(pc_field(w_if_pc, 2, BTB_W));
    assign w_ex_tidx = BTB_W'(pc_field(w_ex_pc, 2, BTB_W));
    assign w_lk_tag  = pc_field(w_if_pc, 2 + BTB_W, TAG_W);
    assign w_ex_tag  = pc_field(w_ex_pc, 2 + BTB_W, TAG_W);

    assign w_idle = (r_state == IDLE);
    assign w_clr  = (r_state == CLEAR);

    assign w_lk_ent = r_btb[w_lk_tidx];
    assign w_hit    = w_lk_ent.valid & (w_lk_ent.tag == w_lk_tag);

    assign if_pred_taken_o  = w_hit & w_idle
                            & (w_lk_ent.jump | w_cnt[w_lk_bidx][CNT_W-1]);
    assign if_pred_target_o = if_pred_taken_o ? XLEN'(w_lk_ent.target) : '0;

    assign w_act = ex_is_jump_i | ex_taken_i;
    assign mispredict_o = rstn & ex_valid_i
        & ((w_act != ex_pred_taken_i)
        | (w_act & ex_pred_taken_i & (ex_target_i != ex_pred_target_i)));
    assign redirect_pc_o = w_act ? ex_target_i : ex_pc_i + XLEN'(4);

    assign w_upd      = ex_valid_i & w_idle & ~flush_i;
    assign w_upd_cond = w_upd & ~ex_is_jump_i;
    assign busy_o     = w_clr;

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        rv_bpu_sat_cnt #(
            .CNT_W(CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rstn  (rstn),
            .i_inc (w_upd_cond & ex_taken_i & (w_ex_bidx == BHT_W'(i))),
            .i_dec (w_upd_cond & ~ex_taken_i & (w_ex_bidx == BHT_W'(i))),
            .i_clr (w_clr & (r_clr_idx == BHT_W'(i))),
            .o_cnt (w_cnt[i])
        );
    end

    // BTB: walk-clear of valid bits, else write on resolved-taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_btb[i] <= '0;
            end
        end else begin
            if (w_clr && (32'(r_clr_idx) < BTB_ENTRIES)) begin
                r_btb[r_clr_idx[BTB_W-1:0]].valid <= 1'b0;
            end
            if (w_upd && w_act) begin
                r_btb[w_ex_tidx] <= '{
                    valid:  1'b1,
                    tag:    w_ex_tag,
                    target: 64'(ex_target_i),
                    jump:   ex_is_jump_i
                };
            end
        end
    end

    // clear FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= IDLE;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    // clear FSM next state; a flush in any state restarts at index 0
    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        unique case (r_state)
            IDLE: begin
                if (flush_i) begin
                    w_state_nxt   = CLEAR;
                    w_clr_idx_nxt = '0;
                end
            end
            CLEAR: begin
                if (flush_i) begin
                    w_clr_idx_nxt = '0;
                end else if (r_clr_idx == BHT_W'(BHT_ENTRIES - 1)) begin
                    w_state_nxt   = IDLE;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + BHT_W'(1);
                end
            end
        endcase
    end

    // saturating perf counters, active in every state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_br <= '0;
            r_perf_mp <= '0;
        end else begin
            if (ex_valid_i && (r_perf_br != 32'hFFFF_FFFF)) begin
                r_perf_br <= r_perf_br + 32'd1;
            end
            if (mispredict_o && (r_perf_mp != 32'hFFFF_FFFF)) begin
                r_perf_mp <= r_perf_mp + 32'd1;
            end
        end
    end

    assign perf_branches_o    = r_perf_br;
    assign perf_mispredicts_o = r_perf_mp;

endmodule

// File: tb/tb_rv_bpu.sv
// Directed bench for rv_bpu: vector table for lookup/resolve,
// hand sequences for table clear, restart and CNT_W=3 saturation.
module tb_rv_bpu;

    logic        clk;
    logic        rstn;
    logic [63:0] if_pc;
    logic        ex_valid;
    logic        ex_is_jump;
    logic [63:0] ex_pc;
    logic        ex_taken;
    logic [63:0] ex_target;
    logic        ex_pred_taken;
    logic [63:0] ex_pred_target;
    logic        flush;

    logic        pt;
    logic [63:0] ptg;
    logic        mis;
    logic [63:0] rd;
    logic        busy;
    logic [31:0] pbr;
    logic [31:0] pmp;

    logic        pt3;
    logic [63:0] ptg3;
    logic        mis3;
    logic [63:0] rd3;
    logic        busy3;
    logic [31:0] pbr3;
    logic [31:0] pmp3;

    int checks = 0;
    int errors = 0;

    rv_bpu u_dut (
        .clk                (clk),
        .rstn               (rstn),
        .if_pc_i            (if_pc),
        .if_pred_taken_o    (pt),
        .if_pred_target_o   (ptg),
        .ex_valid_i         (ex_valid),
        .ex_is_jump_i       (ex_is_jump),
        .ex_pc_i            (ex_pc),
        .ex_taken_i         (ex_taken),
        .ex_target_i        (ex_target),
        .ex_pred_taken_i    (ex_pred_taken),
        .ex_pred_target_i   (ex_pred_target),
        .mispredict_o       (mis),
        .redirect_pc_o      (rd),
        .flush_i            (flush),
        .busy_o             (busy),
        .perf_branches_o    (pbr),
        .perf_mispredicts_o (pmp)
    );

    rv_bpu #(
        .CNT_W(3)
    ) u_dut3 (
        .clk                (clk),
        .rstn               (rstn),
        .if_pc_i            (if_pc),
        .if_pred_taken_o    (pt3),
        .if_pred_target_o   (ptg3),
        .ex_valid_i         (ex_valid),
        .ex_is_jump_i       (ex_is_jump),
        .ex_pc_i            (ex_pc),
        .ex_taken_i         (ex_taken),
        .ex_target_i        (ex_target),
        .ex_pred_taken_i    (ex_pred_taken),
        .ex_pred_target_i   (ex_pred_target),
        .mispredict_o       (mis3),
        .redirect_pc_o      (rd3),
        .flush_i            (flush),
        .busy_o             (busy3),
        .perf_branches_o    (pbr3),
        .perf_mispredicts_o (pmp3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        v;
        logic        j;
        logic [63:0] pc;
        logic        tk;
        logic [63:0] tgt;
        logic        prt;
        logic [63:0] prg;
        logic [63:0] lk;
        logic        e_mis;
        logic [63:0] e_rd;
        logic        e_pt;
        logic [63:0] e_ptg;
        logic [31:0] e_br;
        logic [31:0] e_mp;
    } vec_t;

    vec_t tv [12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic res(input logic j, input logic [63:0] pc,
                       input logic tk, input logic [63:0] tgt);
        @(posedge clk); #1;
        ex_valid = 1'b1; ex_is_jump = j; ex_pc = pc;
        ex_taken = tk; ex_target = tgt;
        ex_pred_taken = 1'b0; ex_pred_target = 64'h0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    task automatic count_busy(output int n, output int nz);
        bit done;
        n = 0; nz = 0; done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (busy) begin
                n++;
                if (pt !== 1'b0 || ptg !== 64'h0) nz++;
            end else begin
                done = 1;
                ex_valid = 1'b0;
            end
        end
        ex_valid = 1'b0;
    endtask

    initial begin
        int n;
        int nz;

        //        v     j     pc        tk    tgt       prt   prg       lk        mis   rd        pt    ptg       br     mp
        tv[0]  = '{1'b1, 1'b0, 64'h100, 1'b1, 64'h80,  1'b0, 64'h0,   64'h100, 1'b1, 64'h80,  1'b0, 64'h0,   32'd0, 32'd0};
        tv[1]  = '{1'b1, 1'b0, 64'h100, 1'b1, 64'h80,  1'b0, 64'h0,   64'h100, 1'b1, 64'h80,  1'b1, 64'h80,  32'd1, 32'd1};
        tv[2]  = '{1'b1, 1'b0, 64'h100, 1'b1, 64'h80,  1'b1, 64'h80,  64'h100, 1'b0, 64'h80,  1'b1, 64'h80,  32'd2, 32'd2};
        tv[3]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b1, 64'h0,   64'h140, 1'b0, 64'h4,   1'b0, 64'h0,   32'd3, 32'd2};
        tv[4]  = '{1'b1, 1'b1, 64'h200, 1'b0, 64'h400, 1'b0, 64'h0,   64'h200, 1'b1, 64'h400, 1'b0, 64'h0,   32'd3, 32'd2};
        tv[5]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b1, 64'h0,   64'h200, 1'b0, 64'h4,   1'b1, 64'h400, 32'd4, 32'd3};
        tv[6]  = '{1'b1, 1'b1, 64'h200, 1'b0, 64'h400, 1'b1, 64'h404, 64'h200, 1'b1, 64'h400, 1'b1, 64'h400, 32'd4, 32'd3};
        tv[7]  = '{1'b1, 1'b0, 64'h500, 1'b0, 64'h600, 1'b1, 64'h600, 64'h500, 1'b1, 64'h504, 1'b0, 64'h0,   32'd5, 32'd4};
        tv[8]  = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b1, 64'h0,   64'h200, 1'b0, 64'h4,   1'b1, 64'h400, 32'd6, 32'd5};
        tv[9]  = '{1'b1, 1'b0, 64'h600, 1'b0, 64'h700, 1'b0, 64'h0,   64'h600, 1'b0, 64'h604, 1'b0, 64'h0,   32'd6, 32'd5};
        tv[10] = '{1'b1, 1'b0, 64'h100, 1'b1, 64'h88,  1'b1, 64'h80,  64'h100, 1'b1, 64'h88,  1'b0, 64'h0,   32'd7, 32'd5};
        tv[11] = '{1'b0, 1'b0, 64'h0,   1'b0, 64'h0,   1'b1, 64'h0,   64'h100, 1'b0, 64'h4,   1'b1, 64'h88,  32'd8, 32'd6};

        rstn = 1'b0; flush = 1'b0; if_pc = 64'h100;
        ex_valid = 1'b0; ex_is_jump = 1'b0; ex_pc = 64'h0;
        ex_taken = 1'b0; ex_target = 64'h0;
        ex_pred_taken = 1'b0; ex_pred_target = 64'h0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        @(negedge clk);
        chk("rst_pred", 64'(pt), 64'h0);
        chk("rst_tgt", ptg, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_mis", 64'(mis), 64'h0);
        chk("rst_rd", rd, 64'h4);
        chk("rst_pbr", 64'(pbr), 64'h0);
        chk("rst_pmp", 64'(pmp), 64'h0);
        chk("rst3_pred", 64'(pt3), 64'h0);
        chk("rst3_tgt", ptg3, 64'h0);
        chk("rst3_busy", 64'(busy3), 64'h0);
        chk("rst3_mis", 64'(mis3), 64'h0);
        chk("rst3_rd", rd3, 64'h4);
        chk("rst3_perf", {pbr3, pmp3}, 64'h0);

        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            ex_valid = tv[i].v; ex_is_jump = tv[i].j; ex_pc = tv[i].pc;
            ex_taken = tv[i].tk; ex_target = tv[i].tgt;
            ex_pred_taken = tv[i].prt; ex_pred_target = tv[i].prg;
            if_pc = tv[i].lk;
            @(negedge clk);
            chk($sformatf("v%0d_mis", i), 64'(mis), 64'(tv[i].e_mis));
            chk($sformatf("v%0d_rd", i), rd, tv[i].e_rd);
            chk($sformatf("v%0d_pt", i), 64'(pt), 64'(tv[i].e_pt));
            chk($sformatf("v%0d_ptg", i), ptg, tv[i].e_ptg);
            chk($sformatf("v%0d_pbr", i), 64'(pbr), 64'(tv[i].e_br));
            chk($sformatf("v%0d_pmp", i), 64'(pmp), 64'(tv[i].e_mp));
        end

        @(posedge clk); #1;
        ex_valid = 1'b0; flush = 1'b1; if_pc = 64'h100;
        @(negedge clk);
        chk("flush_cyc_busy", 64'(busy), 64'h0);
        chk("flush_cyc_pred", 64'(pt), 64'h1);
        @(posedge clk); #1;
        flush = 1'b0;
        ex_valid = 1'b1; ex_is_jump = 1'b1; ex_pc = 64'h300;
        ex_taken = 1'b0; ex_target = 64'h700;
        ex_pred_taken = 1'b0; ex_pred_target = 64'h0;
        count_busy(n, nz);
        chk("clear_len", 64'(n), 64'd64);
        chk("clear_pred_zero", 64'(nz), 64'd0);
        @(negedge clk);
        chk("clear_pbr", 64'(pbr), 64'd72);
        chk("clear_pmp", 64'(pmp), 64'd70);
        chk("post_clear_100", 64'(pt), 64'h0);
        if_pc = 64'h300;
        @(negedge clk);
        chk("post_clear_300", 64'(pt), 64'h0);
        chk("post_clear_300t", ptg, 64'h0);

        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        repeat (20) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        chk("restart_busy", 64'(busy), 64'h1);
        @(posedge clk); #1 flush = 1'b0;
        count_busy(n, nz);
        chk("restart_len", 64'(n), 64'd64);

        for (int i = 0; i < 10; i++) res(1'b0, 64'h304, 1'b1, 64'h900);
        if_pc = 64'h304;
        @(negedge clk);
        chk("sat_taken", 64'(pt3), 64'h1);
        chk("sat_tgt", ptg3, 64'h900);
        for (int i = 0; i < 3; i++) res(1'b0, 64'h304, 1'b0, 64'h900);
        @(negedge clk);
        chk("sat_dec3", 64'(pt3), 64'h1);
        res(1'b0, 64'h304, 1'b0, 64'h900);
        @(negedge clk);
        chk("sat_dec4", 64'(pt3), 64'h0);
        chk("sat_dec4_tgt", ptg3, 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv_bpu.md
Name: rv_bpu

Overview:
- Parametrised branch prediction unit for the 5-stage RV64 pipeline. It replaces the fixed per-address taken flag with a BHT of saturating counters, a tagged direct-mapped BTB, misprediction detection and performance counters.
- IF looks it up in the same cycle from the current PC.
- EX updates it with the resolved outcome and receives the redirect decision.
- flush_i (e.g. FENCE.I) starts a multi-cycle table-clear sequence.

Parameters:
- XLEN, 64, address/data width.
- BHT_ENTRIES, 64, number of BHT counters; power of 2, ≥2.
- BTB_ENTRIES, 16, number of BTB entries; power of 2, ≥2, ≤BHT_ENTRIES.
- CNT_W, 2, counter width; ≥1.
- TAG_W, 12, partial tag width stored per BTB entry.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- if_pc_i  in  XLEN  PC being fetched.
- if_pred_taken_o  out  1  predict taken for if_pc_i.
- if_pred_target_o  out  XLEN  predicted target; 0 when not taken.
- ex_valid_i  in  1  a control-transfer instruction is resolved in EX this cycle.
- ex_is_jump_i  in  1  the resolved instruction is unconditional (JAL/JALR).
- ex_pc_i  in  XLEN  PC of the resolved instruction.
- ex_taken_i  in  1  conditional outcome (ignored when ex_is_jump_i=1).
- ex_target_i  in  XLEN  resolved target.
- ex_pred_taken_i  in  1  prediction made in IF, carried down the pipe.
- ex_pred_target_i  in  XLEN  predicted target, carried down the pipe.
- mispredict_o  out  1  flush IF/ID and redirect.
- redirect_pc_o  out  XLEN  correct next PC.
- flush_i  in  1  request to invalidate all tables.
- busy_o  out  1  clear sequence in progress.
- perf_branches_o  out  32  count of resolved control transfers.
- perf_mispredicts_o  out  32  count of mispredictions.

Behaviour:
- Reset: rstn is asynchronous, active-low; clock is clk. While reset is asserted:
  - all BTB valid bits are 0;
  - all counters are weakly-not-taken, value 2^(CNT_W-1)-1 (0 when CNT_W=1);
  - the FSM is in IDLE;
  - perf counters are 0;
  - busy_o=0, if_pred_taken_o=0, mispredict_o=0.
- Indexing:
  - bht_idx = pc[2 +: log2(BHT_ENTRIES)].
  - btb_idx = pc[2 +: log2(BTB_ENTRIES)].
  - tag = pc[2+log2(BTB_ENTRIES) +: TAG_W].
- BTB entry contents: valid, tag, target[XLEN-1:0], jump bit.
- Lookup (combinational, 0 latency):
  - hit = valid & tag match.
  - if_pred_taken_o = hit & (jump | counter MSB) & (state==IDLE).
  - if_pred_target_o = stored target when taken, else 0.
- Resolution (combinational, evaluated when ex_valid_i=1; otherwise mispredict_o=0):
  - act = ex_is_jump_i | ex_taken_i.
  - mispredict_o = (act != ex_pred_taken_i) | (act & ex_pred_taken_i & ex_target_i != ex_pred_target_i).
  - redirect_pc_o = act ? ex_target_i : ex_pc_i+4.
  - Resolution is computed in every FSM state.
- Update (posedge, only when ex_valid_i & state==IDLE & !flush_i):
  - Conditional branch: the counter saturating-increments if taken, saturating-decrements if not taken.
  - Jump: the counter is untouched.
  - If act=1, the BTB entry is written with valid=1, tag, ex_target_i and jump=ex_is_jump_i.
  - If act=0, the BTB entry is left unchanged.
- Same-cycle lookup and update to the same index: the lookup returns the pre-update value (write takes effect at the clock edge).
- FSM:
  - IDLE→CLEAR on flush_i; clr_idx←0.
  - In CLEAR, each cycle: counter[clr_idx] resets to weakly-not-taken; if clr_idx<BTB_ENTRIES, BTB valid[clr_idx]←0; clr_idx++.
  - CLEAR→IDLE after clr_idx==BHT_ENTRIES-1, i.e. BHT_ENTRIES cycles.
  - busy_o=1 exactly while in CLEAR.
  - flush_i asserted during CLEAR restarts the sequence with clr_idx←0.
  - Updates are dropped during CLEAR and in the flush_i cycle.
- Perf counters:
  - perf_branches_o increments on every ex_valid_i; perf_mispredicts_o increments on every mispredict_o.
  - Both saturate at 2^32-1.
  - Both count in all states and are not cleared by flush_i.

Decomposition:
- Shared package rv_pkg:
  - BPU state enum (IDLE, CLEAR);
  - counter init/saturation helper functions;
  - BTB entry struct;
  - PC index/tag extraction functions.
- One natural sub-module, rv_bpu_sat_cnt: a single CNT_W saturating counter with inc/dec/clear, instantiated BHT_ENTRIES times or used as a next-value function.

Test Plan:
- Reset, then lookup any PC → if_pred_taken_o=0, if_pred_target_o=0, busy_o=0, perf counters 0.
- Conditional branch at 0x100, target 0x80, resolved taken twice with pred=0:
  - mispredict_o=1 with redirect 0x80 both times;
  - next lookup of 0x100 → taken, target 0x80;
  - resolving with pred=1, target 0x80 → mispredict_o=0;
  - perf_branches_o=3, perf_mispredicts_o=2.
- JAL at 0x200, target 0x400, resolved once → next lookup of 0x200 predicts 0x400 despite weak counter. Then resolve with pred target 0x404 → mispredict_o=1, redirect 0x400.
- Aliasing: 0x100 trained taken; lookup of 0x100+4·BTB_ENTRIES (same index, different tag) → not taken.
- flush_i for 1 cycle:
  - busy_o high for exactly BHT_ENTRIES cycles;
  - predictions are 0 and ex updates are ignored during the clear;
  - after the clear, 0x100 predicts not taken;
  - flush_i re-asserted mid-clear extends busy_o to BHT_ENTRIES cycles from the second pulse.
- Counter saturation with CNT_W=3:
  - 10 taken resolutions keep the counter at 7;
  - then 4 not-taken resolutions leave it at 3 → lookup predicts not taken.
